// File: rtl/qpsk_frame_tx.sv
// rtl/qpsk_frame_tx.sv - QPSK transmit framer: preamble, header/payload/checksum, I/Q symbol timing
module qpsk_frame_tx #(
  parameter int          SAMPLE   = 100,
  parameter logic [7:0]  HEADER   = 8'b1100_1100,
  parameter int          PRE_SYMS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sam_en,
  input  logic [39:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        i_bit,
  output logic        q_bit,
  output logic        sym_stb,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW       = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
  localparam int MAX_SYMS = (PRE_SYMS > 28) ? PRE_SYMS : 28;
  localparam int SW       = $clog2(MAX_SYMS);

  localparam logic [CW-1:0] SAM_LAST = CW'(SAMPLE - 1);
  localparam logic [SW-1:0] PRE_LAST = SW'(PRE_SYMS - 1);
  localparam logic [SW-1:0] FRM_LAST = SW'(27);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    FRAME
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] sam_cnt, sam_cnt_n;
  logic [SW-1:0] sym_cnt, sym_cnt_n;
  logic [55:0]   shreg, shreg_n;
  logic          i_n, q_n, stb_n, fd_n, busy_n, ready_n;
  logic [10:0]   sum;
  logic [7:0]    csum;
  logic          sym_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sam_cnt    <= '0;
      sym_cnt    <= '0;
      shreg      <= '0;
      i_bit      <= 1'b0;
      q_bit      <= 1'b0;
      sym_stb    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_n;
      sam_cnt    <= sam_cnt_n;
      sym_cnt    <= sym_cnt_n;
      shreg      <= shreg_n;
      i_bit      <= i_n;
      q_bit      <= q_n;
      sym_stb    <= stb_n;
      busy       <= busy_n;
      frame_done <= fd_n;
      in_ready   <= ready_n;
    end
  end

  always_comb begin
    state_n   = state;
    sam_cnt_n = sam_cnt;
    sym_cnt_n = sym_cnt;
    shreg_n   = shreg;
    i_n       = i_bit;
    q_n       = q_bit;
    stb_n     = 1'b0;
    fd_n      = 1'b0;

    // Wide sum so the five byte carries never wrap before the final mod 256.
    sum  = 11'(in_data[39:32]) + 11'(in_data[31:24]) + 11'(in_data[23:16])
         + 11'(in_data[15:8]) + 11'(in_data[7:0]);
    csum = 8'(sum % 11'd256);

    sym_end = sam_en && (sam_cnt == SAM_LAST);

    case (state)
      IDLE: begin
        sam_cnt_n = '0;
        sym_cnt_n = '0;
        i_n       = 1'b0;
        q_n       = 1'b0;
        if (in_valid && in_ready) begin
          state_n = PRE;
          shreg_n = {HEADER, in_data, csum};
          i_n     = 1'b1;
          q_n     = 1'b1;
          stb_n   = 1'b1;
        end
      end

      PRE: begin
        if (sam_en) begin
          sam_cnt_n = sym_end ? '0 : sam_cnt + CW'(1);
        end
        if (sym_end) begin
          stb_n = 1'b1;
          if (sym_cnt == PRE_LAST) begin
            state_n   = FRAME;
            sym_cnt_n = '0;
            i_n       = shreg[55];
            q_n       = shreg[54];
            shreg_n   = {shreg[53:0], 2'b00};
          end else begin
            // Preamble alternates (1,1)/(0,0), so each new symbol is the inverse.
            sym_cnt_n = sym_cnt + SW'(1);
            i_n       = ~i_bit;
            q_n       = ~q_bit;
          end
        end
      end

      FRAME: begin
        if (sam_en) begin
          sam_cnt_n = sym_end ? '0 : sam_cnt + CW'(1);
        end
        if (sym_end) begin
          if (sym_cnt == FRM_LAST) begin
            state_n   = IDLE;
            sym_cnt_n = '0;
            i_n       = 1'b0;
            q_n       = 1'b0;
            fd_n      = 1'b1;
          end else begin
            sym_cnt_n = sym_cnt + SW'(1);
            i_n       = shreg[55];
            q_n       = shreg[54];
            shreg_n   = {shreg[53:0], 2'b00};
            stb_n     = 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
  end

endmodule
